// File: rtl/dma_read_arbiter.sv
// Round-robin arbiter sharing one DDR read DMA channel between two requesters.
// Each requester's command is latched on its start pulse; the returned stream is steered to the owner until tlast.
module dma_read_arbiter #(
  parameter int DATA_W = 256,
  parameter int KEEP_W = DATA_W / 8,
  parameter int CMD_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_start,
  input  logic [CMD_W-1:0]  req0_cmd,
  input  logic              req1_start,
  input  logic [CMD_W-1:0]  req1_cmd,
  output logic [CMD_W-1:0]  dma_cmd,
  output logic              dma_cmd_valid,
  input  logic [DATA_W-1:0] dma_tdata,
  input  logic [KEEP_W-1:0] dma_tkeep,
  input  logic              dma_tvalid,
  input  logic              dma_tlast,
  output logic              dma_tready,
  output logic [DATA_W-1:0] out0_tdata,
  output logic [KEEP_W-1:0] out0_tkeep,
  output logic              out0_tvalid,
  output logic              out0_tlast,
  input  logic              out0_tready,
  output logic [DATA_W-1:0] out1_tdata,
  output logic [KEEP_W-1:0] out1_tkeep,
  output logic              out1_tvalid,
  output logic              out1_tlast,
  input  logic              out1_tready,
  output logic              done0,
  output logic              done1,
  output logic              busy,
  output logic              owner,
  output logic [1:0]        err_dup
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [1:0]       pending_r;
  logic [1:0]       pending_s;
  logic [CMD_W-1:0] cmd0_r;
  logic [CMD_W-1:0] cmd0_s;
  logic [CMD_W-1:0] cmd1_r;
  logic [CMD_W-1:0] cmd1_s;
  logic [1:0]       err_dup_r;
  logic [1:0]       err_dup_s;
  logic             last_grant_r;
  logic             owner_r;
  logic [CMD_W-1:0] dma_cmd_r;
  logic             dma_cmd_valid_r;
  logic             done0_r;
  logic             done1_r;
  logic             busy_r;
  logic             grant_s;
  logic             launch_s;
  logic             stream_s;
  logic             tready_s;
  logic             complete_s;
  logic             complete0_s;
  logic             complete1_s;

  // Ties go to the requester that was not served last.
  function automatic logic rr_pick(input logic [1:0] pend, input logic last);
    logic pick;
    if (pend == 2'b11) begin
      pick = ~last;
    end else if (pend[1]) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
    return pick;
  endfunction

  assign stream_s    = (state_r == ST_STREAM);
  assign launch_s    = (state_r == ST_IDLE) && (pending_r != 2'b00);
  assign grant_s     = rr_pick(pending_r, last_grant_r);
  assign complete_s  = stream_s & dma_tvalid & tready_s & dma_tlast;
  assign complete0_s = complete_s & ~owner_r;
  assign complete1_s = complete_s & owner_r;

  // Request capture: a completing beat frees the slot before a same-cycle start re-arms it.
  always_comb begin
    pending_s = pending_r;
    cmd0_s    = cmd0_r;
    cmd1_s    = cmd1_r;
    err_dup_s = err_dup_r;
    if (req0_start) begin
      if (!pending_r[0] || complete0_s) begin
        pending_s[0] = 1'b1;
        cmd0_s       = req0_cmd;
      end else begin
        err_dup_s[0] = 1'b1;
      end
    end else if (complete0_s) begin
      pending_s[0] = 1'b0;
    end else begin
      pending_s[0] = pending_r[0];
    end
    if (req1_start) begin
      if (!pending_r[1] || complete1_s) begin
        pending_s[1] = 1'b1;
        cmd1_s       = req1_cmd;
      end else begin
        err_dup_s[1] = 1'b1;
      end
    end else if (complete1_s) begin
      pending_s[1] = 1'b0;
    end else begin
      pending_s[1] = pending_r[1];
    end
  end

  // Channel FSM next state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (launch_s) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_s = ST_STREAM;
      end
      ST_STREAM: begin
        if (complete_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_STREAM;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Stream steering: only the owner sees the DMA stream, and only while streaming.
  always_comb begin
    out0_tdata  = {DATA_W{1'b0}};
    out0_tkeep  = {KEEP_W{1'b0}};
    out0_tvalid = 1'b0;
    out0_tlast  = 1'b0;
    out1_tdata  = {DATA_W{1'b0}};
    out1_tkeep  = {KEEP_W{1'b0}};
    out1_tvalid = 1'b0;
    out1_tlast  = 1'b0;
    tready_s    = 1'b0;
    if (stream_s) begin
      if (owner_r) begin
        out1_tdata  = dma_tdata;
        out1_tkeep  = dma_tkeep;
        out1_tvalid = dma_tvalid;
        out1_tlast  = dma_tlast;
        tready_s    = out1_tready;
      end else begin
        out0_tdata  = dma_tdata;
        out0_tkeep  = dma_tkeep;
        out0_tvalid = dma_tvalid;
        out0_tlast  = dma_tlast;
        tready_s    = out0_tready;
      end
    end else begin
      tready_s = 1'b0;
    end
  end

  // State, request slots and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      pending_r       <= 2'b00;
      cmd0_r          <= {CMD_W{1'b0}};
      cmd1_r          <= {CMD_W{1'b0}};
      err_dup_r       <= 2'b00;
      dma_cmd_valid_r <= 1'b0;
      done0_r         <= 1'b0;
      done1_r         <= 1'b0;
      busy_r          <= 1'b0;
    end else begin
      state_r         <= state_s;
      pending_r       <= pending_s;
      cmd0_r          <= cmd0_s;
      cmd1_r          <= cmd1_s;
      err_dup_r       <= err_dup_s;
      dma_cmd_valid_r <= launch_s;
      done0_r         <= complete0_s;
      done1_r         <= complete1_s;
      busy_r          <= (state_s != ST_IDLE) || (pending_s != 2'b00);
    end
  end

  // Grant bookkeeping; dma_cmd and owner hold until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= 1'b1;
      owner_r      <= 1'b0;
      dma_cmd_r    <= {CMD_W{1'b0}};
    end else begin
      if (launch_s) begin
        owner_r   <= grant_s;
        dma_cmd_r <= grant_s ? cmd1_r : cmd0_r;
      end else begin
        owner_r   <= owner_r;
        dma_cmd_r <= dma_cmd_r;
      end
      if (complete_s) begin
        last_grant_r <= owner_r;
      end else begin
        last_grant_r <= last_grant_r;
      end
    end
  end

  assign dma_tready    = tready_s;
  assign dma_cmd       = dma_cmd_r;
  assign dma_cmd_valid = dma_cmd_valid_r;
  assign done0         = done0_r;
  assign done1         = done1_r;
  assign busy          = busy_r;
  assign owner         = owner_r;
  assign err_dup       = err_dup_r;

endmodule
